// File: rtl/nv_nvdla_sdp_wdma_dfifo_sched.sv
`default_nettype none
// ============================================================================
//  Module   : nv_nvdla_sdp_wdma_dfifo_sched
//  Purpose  : Command-driven scheduler that drains the four WDMA data FIFOs
//             in strict round-robin order into one ordered atom stream.
//             Each command names a start FIFO and an atom count (minus one).
//             The final atom of a command is tagged, completion is pulsed,
//             and a saturating atom counter is kept for register readback.
//  Ports    : nvdla_core_clk/nvdla_core_rstn - clock, async active-low reset
//             cmd_pvld/cmd_prdy/cmd_pd        - command handshake
//             dfifo_rd_pvld/prdy/pd           - four FIFO read ports
//             dat_pvld/dat_prdy/dat_pd        - merged output atom stream
//             op_load                         - clears the atom counter
//             cmd_done, busy, dp2reg_atom_cnt - status
//  Revision : 1.0 - initial release
// ============================================================================
module nv_nvdla_sdp_wdma_dfifo_sched #(
    parameter int DW   = 128,
    parameter int CNTW = 13
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic                cmd_pvld,
    output logic                cmd_prdy,
    input  logic [CNTW+1:0]     cmd_pd,
    input  logic [3:0]          dfifo_rd_pvld,
    output logic [3:0]          dfifo_rd_prdy,
    input  logic [4*DW-1:0]     dfifo_rd_pd,
    output logic                dat_pvld,
    input  logic                dat_prdy,
    output logic [DW:0]         dat_pd,
    input  logic                op_load,
    output logic                cmd_done,
    output logic                busy,
    output logic [31:0]         dp2reg_atom_cnt
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            dat_pvld_q, dat_pvld_d;
    logic [DW:0]     dat_pd_q, dat_pd_d;
    logic            done_q, done_d;
    logic [31:0]     atom_cnt_q, atom_cnt_d;

    logic            w_out_free;
    logic            w_pop;
    logic            w_cnt_zero;
    logic            w_cmd_acc;
    logic [DW-1:0]   w_sel_pd;

    // The output register can take a new atom when empty or draining now.
    assign w_out_free = !dat_pvld_q || dat_prdy;
    assign w_pop      = |(dfifo_rd_prdy & dfifo_rd_pvld);
    assign w_cnt_zero = (cnt_q == '0);
    assign w_cmd_acc  = cmd_pvld && cmd_prdy;
    assign w_sel_pd   = dfifo_rd_pd[ptr_q*DW +: DW];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (cmd_pvld)              state_d = c_ST_RUN;
            c_ST_RUN:  if (w_pop && w_cnt_zero)   state_d = c_ST_IDLE;
            default:                              state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: only the pointed-to FIFO is ever popped, so an empty
    // FIFO stalls the stream rather than letting the pointer skip ahead.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_prdy      = (state_q == c_ST_IDLE);
        dfifo_rd_prdy = 4'b0000;
        if ((state_q == c_ST_RUN) && w_out_free) begin
            dfifo_rd_prdy = 4'b0001 << ptr_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        dat_pvld_d = dat_pvld_q;
        dat_pd_d   = dat_pd_q;
        done_d     = w_pop && w_cnt_zero;

        if (w_cmd_acc) begin
            cnt_d = cmd_pd[CNTW-1:0];
            ptr_d = cmd_pd[CNTW+1:CNTW];
        end else if (w_pop) begin
            ptr_d = ptr_q + 2'd1;
            if (!w_cnt_zero) begin
                cnt_d = cnt_q - CNTW'(1);
            end
        end

        // A pop in the same cycle as a drain reloads with no bubble.
        if (w_pop) begin
            dat_pvld_d = 1'b1;
            dat_pd_d   = {w_cnt_zero, w_sel_pd};
        end else if (dat_prdy) begin
            dat_pvld_d = 1'b0;
        end
    end

    // op_load wins over a coincident transfer; the counter saturates.
    always_comb begin
        atom_cnt_d = atom_cnt_q;
        if (op_load) begin
            atom_cnt_d = '0;
        end else if (dat_pvld_q && dat_prdy && (atom_cnt_q != 32'hFFFF_FFFF)) begin
            atom_cnt_d = atom_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q      <= '0;
            ptr_q      <= '0;
            dat_pvld_q <= 1'b0;
            dat_pd_q   <= '0;
            done_q     <= 1'b0;
            atom_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            dat_pvld_q <= dat_pvld_d;
            dat_pd_q   <= dat_pd_d;
            done_q     <= done_d;
            atom_cnt_q <= atom_cnt_d;
        end
    end

    assign dat_pvld        = dat_pvld_q;
    assign dat_pd          = dat_pd_q;
    assign cmd_done        = done_q;
    assign busy            = (state_q == c_ST_RUN) || dat_pvld_q;
    assign dp2reg_atom_cnt = atom_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_sdp_wdma_dfifo_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nv_nvdla_sdp_wdma_dfifo_sched
//  Purpose  : Self-checking bench for the WDMA dfifo scheduler. The four
//             FIFOs are emulated as arrays of random words; the expected
//             output stream is built per command from the round-robin rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_sdp_wdma_dfifo_sched;

    localparam int DW   = 128;
    localparam int CNTW = 13;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_pvld = 1'b0;
    logic              cmd_prdy;
    logic [CNTW+1:0]   cmd_pd = '0;
    logic [3:0]        dfifo_rd_pvld = 4'hF;
    logic [3:0]        dfifo_rd_prdy;
    logic [4*DW-1:0]   dfifo_rd_pd;
    logic              dat_pvld;
    logic              dat_prdy = 1'b1;
    logic [DW:0]       dat_pd;
    logic              op_load = 1'b0;
    logic              cmd_done;
    logic              busy;
    logic [31:0]       dp2reg_atom_cnt;

    nv_nvdla_sdp_wdma_dfifo_sched #(.DW(DW), .CNTW(CNTW)) u_dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cmd_pvld        (cmd_pvld),
        .cmd_prdy        (cmd_prdy),
        .cmd_pd          (cmd_pd),
        .dfifo_rd_pvld   (dfifo_rd_pvld),
        .dfifo_rd_prdy   (dfifo_rd_prdy),
        .dfifo_rd_pd     (dfifo_rd_pd),
        .dat_pvld        (dat_pvld),
        .dat_prdy        (dat_prdy),
        .dat_pd          (dat_pd),
        .op_load         (op_load),
        .cmd_done        (cmd_done),
        .busy            (busy),
        .dp2reg_atom_cnt (dp2reg_atom_cnt)
    );

    always #5 clk = ~clk;

    // FIFO emulation: each FIFO is a fixed array of random words.
    logic [DW-1:0] mem [4][512];
    logic [8:0]    rd_idx [4];
    int            model_idx [4];
    logic [DW:0]   exp_q [$];
    logic [3:0]    pend_pop = 4'b0;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_xfer = 0;
    int            n_done = 0;
    logic [31:0]   model_cnt = '0;
    logic          prev_pvld = 1'b0;
    logic          prev_prdy = 1'b0;
    logic [DW:0]   prev_pd   = '0;
    bit            rand_prdy = 1'b0;
    bit            rand_pvld = 1'b0;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_fifo
            assign dfifo_rd_pd[g*DW +: DW] = mem[g][rd_idx[g]];
        end
    endgenerate

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Pops sampled at the negedge take effect at the following posedge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (pend_pop[i]) rd_idx[i] <= rd_idx[i] + 9'd1;
    end

    // Random stimulus on the handshake inputs when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_prdy) dat_prdy = 1'($urandom % 2);
        if (rand_pvld) dfifo_rd_pvld = 4'($urandom);
    end

    // Output monitor and reference checks.
    always @(negedge clk) begin
        logic is_new;
        pend_pop = dfifo_rd_prdy & dfifo_rd_pvld;
        if (rstn) begin
            check("rdprdy_onehot", ($countones(dfifo_rd_prdy) <= 1), 1);
            if (dat_pvld && !dat_prdy) check("rdprdy_when_full", dfifo_rd_prdy, 0);
            if (prev_pvld && !prev_prdy) begin
                check("hold_pvld", dat_pvld, 1);
                check("hold_pd", dat_pd, prev_pd);
            end
            is_new = dat_pvld && !(prev_pvld && !prev_prdy);
            if (cmd_done || (is_new && dat_pd[DW]))
                check("done_align", cmd_done, is_new && dat_pd[DW]);
            if (cmd_done) n_done++;
            if (dat_pvld && dat_prdy) begin
                check("atom_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("atom_data", dat_pd, exp_q.pop_front());
                n_xfer++;
            end
            check("atom_cnt", dp2reg_atom_cnt, model_cnt);
            if (op_load) model_cnt = '0;
            else if (dat_pvld && dat_prdy && model_cnt != 32'hFFFF_FFFF) model_cnt++;
        end
        prev_pvld = rstn && dat_pvld;
        prev_prdy = dat_prdy;
        prev_pd   = dat_pd;
    end

    task automatic send_cmd(input int s, input int c);
        bit acc = 1'b0;
        int f;
        @(posedge clk); #1;
        cmd_pvld = 1'b1;
        cmd_pd   = {2'(s), CNTW'(c)};
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_prdy;
            @(posedge clk); #1;
        end
        cmd_pvld = 1'b0;
        check("cmd_accept", acc, 1);
        if (acc) begin
            for (int k = 0; k <= c; k++) begin
                f = (s + k) % 4;
                exp_q.push_back({(k == c), mem[f][model_idx[f]]});
                model_idx[f]++;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            ok = !busy && (exp_q.size() == 0);
        end
        check(tag, ok, 1);
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d0, x0;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            rd_idx[i]    = '0;
            model_idx[i] = 0;
            for (int j = 0; j < 512; j++)
                mem[i][j] = {$urandom, $urandom, $urandom, $urandom};
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_prdy", cmd_prdy, 1);
        check("rst_rd_prdy", dfifo_rd_prdy, 0);
        check("rst_dat_pvld", dat_pvld, 0);
        check("rst_dat_pd", dat_pd, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_busy", busy, 0);
        check("rst_atom_cnt", dp2reg_atom_cnt, 0);
        #2 rstn = 1'b1;

        // Six atoms from start FIFO 1
        d0 = n_done;
        send_cmd(1, 5);
        wait_idle("t1_drain");
        check("t1_done_pulses", n_done - d0, 1);
        check("t1_atom_cnt", dp2reg_atom_cnt, 6);

        // Single atom from FIFO 3, cmd_prdy back one cycle after the pop
        send_cmd(3, 0);
        @(negedge clk);
        check("t2_rd_prdy", dfifo_rd_prdy, 4'b1000);
        check("t2_cmd_prdy_low", cmd_prdy, 0);
        @(negedge clk);
        check("t2_cmd_prdy_high", cmd_prdy, 1);
        check("t2_cmd_done", cmd_done, 1);
        wait_idle("t2_drain");

        // FIFO 1 empty: stall on FIFO 1, never skip to 2 or 3
        @(posedge clk); #1;
        dfifo_rd_pvld = 4'b1101;
        send_cmd(0, 3);
        @(negedge clk);
        check("t3_first_pop", dfifo_rd_prdy, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_stall_rd_prdy", dfifo_rd_prdy, 4'b0010);
        end
        @(posedge clk); #1;
        dfifo_rd_pvld = 4'hF;
        wait_idle("t3_drain");

        // 100-atom command with random backpressure and FIFO validity
        rand_prdy = 1'b1;
        rand_pvld = 1'b1;
        send_cmd(int'($urandom_range(0, 3)), 99);
        wait_idle("t4_drain");
        rand_prdy = 1'b0;
        rand_pvld = 1'b0;
        @(posedge clk); #1;
        dat_prdy = 1'b1;
        dfifo_rd_pvld = 4'hF;

        // op_load coincident with a transfer at counter=41
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
        send_cmd(2, 40);
        wait_idle("t5_drain_a");
        check("t5_cnt_41", dp2reg_atom_cnt, 41);
        dat_prdy = 1'b0;
        send_cmd(1, 0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = dat_pvld;
        end
        check("t5_atom_held", seen, 1);
        @(posedge clk); #1;
        dat_prdy = 1'b1;
        op_load  = 1'b1;
        @(posedge clk); #1;
        op_load  = 1'b0;
        @(negedge clk);
        check("t5_cnt_cleared", dp2reg_atom_cnt, 0);
        send_cmd(2, 0);
        wait_idle("t5_drain_b");
        check("t5_cnt_one", dp2reg_atom_cnt, 1);

        // Reset mid-command, then a clean command
        x0 = n_xfer;
        send_cmd(0, 7);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = (n_xfer - x0) >= 3;
        end
        check("t6_three_atoms", seen, 1);
        @(posedge clk); #3;
        rstn = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) model_idx[i] = int'(rd_idx[i]);
        model_cnt = '0;
        #1;
        check("t6_rst_cmd_prdy", cmd_prdy, 1);
        check("t6_rst_rd_prdy", dfifo_rd_prdy, 0);
        check("t6_rst_dat_pvld", dat_pvld, 0);
        check("t6_rst_dat_pd", dat_pd, 0);
        check("t6_rst_cmd_done", cmd_done, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_atom_cnt", dp2reg_atom_cnt, 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        send_cmd(2, 1);
        wait_idle("t6_drain");
        check("t6_atom_cnt", dp2reg_atom_cnt, 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
